// File: rtl/icache_direct_if.sv
// Bus bundle between the IF stage, the instruction cache and the memory controller.
// The cache uses the slave modport; the environment (IF stage plus controller) uses master.
interface icache_direct_if;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_complete;
  logic [31:0] mem_value;
  logic        flush;

  // Handshakes: if_valid qualifies if_instr in the cycle if_req is seen, with no
  // back-pressure. mem_req is a level-held request with a stable mem_addr.
  // mem_complete is a one-cycle acknowledge carrying mem_value, and mem_req drops
  // in that same cycle. flush withdraws mem_req and the controller abandons the refill.
  modport slave (
    input  if_req, if_pc, mem_complete, mem_value, flush,
    output if_valid, if_instr, mem_req, mem_addr
  );

  modport master (
    output if_req, if_pc, mem_complete, mem_value, flush,
    input  if_valid, if_instr, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped blocking instruction cache: one 32-bit word per line, single refill in flight.
// Optional macro ICACHE_REFILL_FWD_EN forwards the refilled word to the IF stage in the completion cycle.
module icache_direct #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_BITS  = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  icache_direct_if.slave   bus,
  output logic             dbg_state_o
);
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           miss_addr_q, miss_addr_d;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES];

  logic [INDEX_BITS-1:0] pc_idx, miss_idx;
  logic [TAG_BITS-1:0]   pc_tag, miss_tag;
  logic                  hit, refill_done;
  logic                  pc_offset_unused;

  assign pc_idx           = bus.if_pc[INDEX_BITS+1:2];
  assign pc_tag           = bus.if_pc[ADDR_BITS-1:INDEX_BITS+2];
  assign miss_idx         = miss_addr_q[INDEX_BITS+1:2];
  assign miss_tag         = miss_addr_q[ADDR_BITS-1:INDEX_BITS+2];
  assign pc_offset_unused = ^bus.if_pc[1:0];

  assign hit         = bus.if_req && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  // A completion that coincides with flush still carries correct data, so it is written.
  assign refill_done = (state_q == S_MISS) && bus.mem_complete && rdy;

  assign bus.mem_req  = (state_q == S_MISS) && !bus.mem_complete && !bus.flush;
  assign bus.mem_addr = (state_q == S_MISS) ? miss_addr_q : '0;
  assign dbg_state_o  = state_q;

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    case (state_q)
      S_IDLE: begin
        if (hit && !bus.flush && rdy) begin
          bus.if_valid = 1'b1;
          bus.if_instr = data_q[pc_idx];
        end
        if (bus.if_req && !hit && !bus.flush && rdy) begin
          miss_addr_d = {bus.if_pc[31:2], 2'b00};
          state_d     = S_MISS;
        end
      end
      S_MISS: begin
        if (rdy && (bus.mem_complete || bus.flush)) begin
          state_d = S_IDLE;
        end
`ifdef ICACHE_REFILL_FWD_EN
        if (bus.mem_complete && bus.if_req && !bus.flush && rdy &&
            (bus.if_pc[ADDR_BITS-1:2] == miss_addr_q[ADDR_BITS-1:2])) begin
          bus.if_valid = 1'b1;
          bus.if_instr = bus.mem_value;
        end
`else
        // Without forwarding the refilled word is served by the next-cycle hit.
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (refill_done) begin
        valid_q[miss_idx] <= 1'b1;
      end
    end
  end

  // Tag and data need no reset: valid_q guards every read.
  always_ff @(posedge clk) begin
    if (refill_done) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= bus.mem_value;
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct; honours ICACHE_REFILL_FWD_EN when defined.
module tb_icache_direct;
`ifdef ICACHE_REFILL_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  logic clk, rst, rdy;
  logic dbg_state;
  int   errors = 0;
  int   checks = 0;

  icache_direct_if bus();

  icache_direct dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Driver tasks: inputs change on the falling edge, outputs are sampled 1 ns later.
  task automatic drive(input logic req, input logic [31:0] pc);
    @(negedge clk);
    bus.if_req       = req;
    bus.if_pc        = pc;
    bus.mem_complete = 1'b0;
    bus.mem_value    = '0;
    bus.flush        = 1'b0;
    #1;
  endtask

  task automatic pulse(input logic [31:0] val, input logic fl);
    @(negedge clk);
    bus.mem_complete = 1'b1;
    bus.mem_value    = val;
    bus.flush        = fl;
    #1;
  endtask

  // Setup-only refill: miss on a, complete with v, back in IDLE afterwards.
  task automatic fill(input logic [31:0] a, input logic [31:0] v);
    drive(1'b1, a);
    pulse(v, 1'b0);
    drive(1'b0, a);
  endtask

  task automatic test_reset;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b want 0", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %0b want 0", bus.if_valid); end
    checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr: got %h want 0", bus.if_instr); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %0b want 0", dbg_state); end
  endtask

  task automatic test_cold_miss;
    drive(1'b1, 32'h0000_1000);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL cold_lookup_valid: got %0b want 0", bus.if_valid); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL cold_lookup_req: got %0b want 0", bus.mem_req); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0000_1000);
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL cold_wait_req: got %0b want 1", bus.mem_req); end
      checks++; if (bus.mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL cold_wait_addr: got %h want 00001000", bus.mem_addr); end
    end
    pulse(32'h0050_0093, 1'b0);
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL cold_pulse_req: got %0b want 0", bus.mem_req); end
    checks++; if (bus.if_valid !== FWD) begin errors++; $display("FAIL cold_pulse_valid: got %0b want %0b", bus.if_valid, FWD); end
    if (FWD) begin
      checks++; if (bus.if_instr !== 32'h0050_0093) begin errors++; $display("FAIL cold_pulse_fwd: got %h want 00500093", bus.if_instr); end
    end
    drive(1'b1, 32'h0000_1000);
    checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL cold_next_valid: got %0b want 1", bus.if_valid); end
    checks++; if (bus.if_instr !== 32'h0050_0093) begin errors++; $display("FAIL cold_next_instr: got %h want 00500093", bus.if_instr); end
  endtask

  task automatic test_warm_hit;
    drive(1'b1, 32'h0000_1000);
    checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL warm_valid: got %0b want 1", bus.if_valid); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL warm_req: got %0b want 0", bus.mem_req); end
    // Bit 18 lies above the decoded address range and must not affect the tag.
    drive(1'b1, 32'h0004_1000);
    checks++; if (bus.if_instr !== 32'h0050_0093) begin errors++; $display("FAIL warm_high_bits: got %h want 00500093", bus.if_instr); end
    rdy = 1'b0;
    drive(1'b1, 32'h0000_1000);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rdy_low_hit: got %0b want 0", bus.if_valid); end
    drive(1'b1, 32'h0000_7000);
    drive(1'b0, 32'h0000_7000);
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL rdy_low_no_miss: got %0b want 0", dbg_state); end
    rdy = 1'b1;
  endtask

  task automatic test_conflict;
    drive(1'b1, 32'h0000_1100);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL conflict_miss: got %0b want 0", bus.if_valid); end
    drive(1'b1, 32'h0000_1100);
    checks++; if (bus.mem_addr !== 32'h0000_1100) begin errors++; $display("FAIL conflict_addr: got %h want 00001100", bus.mem_addr); end
    pulse(32'h1111_1111, 1'b0);
    drive(1'b1, 32'h0000_1100);
    checks++; if (bus.if_instr !== 32'h1111_1111) begin errors++; $display("FAIL conflict_new: got %h want 11111111", bus.if_instr); end
    drive(1'b1, 32'h0000_1000);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL conflict_evicted: got %0b want 0", bus.if_valid); end
    drive(1'b1, 32'h0000_1000);
    checks++; if (bus.mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL conflict_refetch_addr: got %h want 00001000", bus.mem_addr); end
    pulse(32'h0050_0093, 1'b0);
  endtask

  task automatic test_flush_mid_refill;
    drive(1'b1, 32'h0000_2000);
    drive(1'b1, 32'h0000_2000);
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL flush_pre_req: got %0b want 1", bus.mem_req); end
    drive(1'b1, 32'h0000_2000);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL flush_req: got %0b want 0", bus.mem_req); end
    drive(1'b1, 32'h0000_2000);
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL flush_state: got %0b want 0", dbg_state); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL flush_no_write: got %0b want 0", bus.if_valid); end
    drive(1'b1, 32'h0000_2000);
    checks++; if (bus.mem_addr !== 32'h0000_2000) begin errors++; $display("FAIL flush_remiss_addr: got %h want 00002000", bus.mem_addr); end
    pulse(32'h0000_2222, 1'b0);
    // Flush in IDLE must not start a miss.
    drive(1'b1, 32'h0000_6000);
    bus.flush = 1'b1;
    #1;
    drive(1'b0, 32'h0000_6000);
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL flush_idle_req: got %0b want 0", bus.mem_req); end
  endtask

  task automatic test_flush_with_complete;
    drive(1'b1, 32'h0000_3000);
    drive(1'b1, 32'h0000_3000);
    pulse(32'h3333_0013, 1'b1);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL flushcpl_valid: got %0b want 0", bus.if_valid); end
    drive(1'b1, 32'h0000_3000);
    checks++; if (bus.if_instr !== 32'h3333_0013) begin errors++; $display("FAIL flushcpl_hit: got %h want 33330013", bus.if_instr); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL flushcpl_req: got %0b want 0", bus.mem_req); end
  endtask

  task automatic test_pc_change_in_miss;
    drive(1'b1, 32'h0000_0004);
    drive(1'b1, 32'h0000_3000);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL miss_blocks_hit: got %0b want 0", bus.if_valid); end
    checks++; if (bus.mem_addr !== 32'h0000_0004) begin errors++; $display("FAIL miss_addr_held: got %h want 00000004", bus.mem_addr); end
    pulse(32'h0444_0004, 1'b0);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL pcchg_pulse_valid: got %0b want 0", bus.if_valid); end
    drive(1'b1, 32'h0000_0004);
    checks++; if (bus.if_instr !== 32'h0444_0004) begin errors++; $display("FAIL pcchg_hit: got %h want 04440004", bus.if_instr); end
    drive(1'b1, 32'h0000_3000);
    checks++; if (bus.if_instr !== 32'h3333_0013) begin errors++; $display("FAIL pcchg_other_line: got %h want 33330013", bus.if_instr); end
  endtask

  task automatic test_async_reset;
    drive(1'b1, 32'h0000_5008);
    drive(1'b1, 32'h0000_5008);
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL areset_pre_req: got %0b want 1", bus.mem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL areset_req: got %0b want 0", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL areset_addr: got %h want 0", bus.mem_addr); end
    #1 rst = 1'b0;
    drive(1'b1, 32'h0000_3000);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL areset_invalid: got %0b want 0", bus.if_valid); end
    drive(1'b1, 32'h0000_3000);
    checks++; if (bus.mem_addr !== 32'h0000_3000) begin errors++; $display("FAIL areset_remiss: got %h want 00003000", bus.mem_addr); end
    pulse(32'h3333_0013, 1'b0);
    drive(1'b0, 32'h0);
  endtask

  initial begin
    rst              = 1'b1;
    rdy              = 1'b1;
    bus.if_req       = 1'b0;
    bus.if_pc        = '0;
    bus.mem_complete = 1'b0;
    bus.mem_value    = '0;
    bus.flush        = 1'b0;
    #3;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_cold_miss();
    test_warm_hit();
    test_conflict();
    test_flush_mid_refill();
    test_flush_with_complete();
    test_pc_change_in_miss();
    test_async_reset();
    fill(32'h0000_0100, 32'h0000_0100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
